// File: rtl/nios_pwm_pkg.sv
// nios_pwm_pkg: shared constants and state type for the PWM ramp controller
package nios_pwm_pkg;
    localparam int DUTY_W_DEF = 16;
    localparam logic [1:0] ADDR_TARGET = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STEP   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_BUSY   = 2;
    localparam int CTRL_DONE   = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_HOLD} state_t;
endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: saturating next-duty computation applied at each boundary tick
module pwm_ramp_step #(
    parameter int DUTY_W = 16
) (
    input  logic [DUTY_W-1:0] i_duty,
    input  logic [DUTY_W-1:0] i_target,
    input  logic [DUTY_W-1:0] i_step,
    output logic [DUTY_W-1:0] o_duty_next
);
    logic [DUTY_W:0] w_up;
    logic [DUTY_W:0] w_dn;
    always_comb begin
        w_up = {1'b0, i_duty} + {1'b0, i_step};
        w_dn = {1'b0, i_duty} - {1'b0, i_step};
        o_duty_next = (i_step == '0) ? i_target :
                      (i_duty < i_target) ? ((w_up > {1'b0, i_target}) ? i_target : w_up[DUTY_W-1:0]) :
                      (i_duty > i_target) ? ((w_dn[DUTY_W] || (w_dn[DUTY_W-1:0] < i_target)) ? i_target : w_dn[DUTY_W-1:0]) :
                      i_duty;
    end
endmodule

// File: rtl/nios_system_pwm_ramp_ctrl.sv
// nios_system_pwm_ramp_ctrl: Avalon-MM PWM generator whose duty ramps toward a target once per period
module nios_system_pwm_ramp_ctrl
    import nios_pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_out,
    output logic              irq
);
    logic [DUTY_W-1:0] r_target, r_period_sh, r_period_act, r_step, r_cnt, r_duty;
    logic              r_enable, r_irq_en, r_done, r_pwm;
    state_t            r_state;
    logic              w_wr, w_wr_tgt, w_wr_per, w_wr_step, w_wr_ctrl;
    logic              w_tick, w_en_next, w_busy, w_done_set, w_done_clr;
    logic [DUTY_W-1:0] w_wdata, w_tgt_eff, w_step_eff, w_per_eff, w_duty_step, w_duty_next;
    state_t            w_state_next;
    logic              w_unused;

    assign w_wr       = chipselect && !write_n;
    assign w_wr_tgt   = w_wr && (address == ADDR_TARGET);
    assign w_wr_per   = w_wr && (address == ADDR_PERIOD);
    assign w_wr_step  = w_wr && (address == ADDR_STEP);
    assign w_wr_ctrl  = w_wr && (address == ADDR_CTRL);
    assign w_wdata    = writedata[DUTY_W-1:0];
    assign w_unused   = ^writedata[31:DUTY_W];
    assign w_tick     = r_enable && (r_cnt == r_period_act);
    // Same-cycle register writes are visible to a boundary tick in that cycle
    assign w_tgt_eff  = w_wr_tgt ? w_wdata : r_target;
    assign w_step_eff = w_wr_step ? w_wdata : r_step;
    assign w_per_eff  = w_wr_per ? w_wdata : r_period_sh;
    assign w_en_next  = w_wr_ctrl ? writedata[CTRL_EN] : r_enable;
    assign w_duty_next = w_tick ? w_duty_step : r_duty;
    assign w_busy     = r_duty != r_target;
    assign w_done_clr = w_wr_ctrl && writedata[CTRL_DONE];
    assign w_state_next = !w_en_next ? ST_IDLE : (w_duty_next != w_tgt_eff) ? ST_RAMP : ST_HOLD;
    assign w_done_set = (r_state == ST_RAMP) && (w_state_next == ST_HOLD);

    pwm_ramp_step #(.DUTY_W(DUTY_W)) u_step (
        .i_duty      (r_duty),
        .i_target    (w_tgt_eff),
        .i_step      (w_step_eff),
        .o_duty_next (w_duty_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target     <= '0;
            r_period_sh  <= '0;
            r_period_act <= '0;
            r_step       <= '0;
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_cnt        <= '0;
            r_duty       <= '0;
            r_pwm        <= 1'b0;
        end else begin
            if (w_wr_tgt) r_target <= w_wdata;
            if (w_wr_per) r_period_sh <= w_wdata;
            if (w_wr_step) r_step <= w_wdata;
            if (w_wr_ctrl) begin
                r_enable <= writedata[CTRL_EN];
                r_irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (!r_enable || w_tick) r_period_act <= w_per_eff;
            r_cnt  <= (!r_enable || w_tick) ? '0 : r_cnt + 1'b1;
            r_duty <= w_duty_next;
            // A disabling write drops the output on the very next cycle
            r_pwm  <= w_en_next && r_enable && (r_cnt < r_duty);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_set || (r_done && !w_done_clr);
        end
    end

    always_comb begin
        readdata = (address == ADDR_TARGET) ? 32'(r_target) :
                   (address == ADDR_PERIOD) ? 32'(r_period_sh) :
                   (address == ADDR_STEP)   ? 32'(r_step) :
                   {28'd0, r_done, w_busy, r_irq_en, r_enable};
    end

    assign pwm_out  = r_pwm;
    assign duty_out = r_duty;
    assign irq      = r_done && r_irq_en;
endmodule

// File: tb/tb_nios_system_pwm_ramp_ctrl.sv
// tb_nios_system_pwm_ramp_ctrl: directed scenarios plus random traffic against a cycle reference model
module tb_nios_system_pwm_ramp_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pwm_out;
    logic [15:0] duty_out;
    logic        irq;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        pwm;
        logic [15:0] duty;
        logic        irq;
        logic [31:0] rd;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int m_tgt, m_psh, m_pact, m_step, m_cnt, m_duty;
    bit m_en, m_ien, m_done, m_pwm, m_ramp;

    nios_system_pwm_ramp_ctrl dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pwm_out(pwm_out), .duty_out(duty_out), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if ({pwm_out, duty_out, irq, readdata} !== e) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got pwm=%b duty=%h irq=%b rd=%h, expected pwm=%b duty=%h irq=%b rd=%h",
                         $time, pwm_out, duty_out, irq, readdata, e.pwm, e.duty, e.irq, e.rd);
            end
        end
    end

    function automatic int ramp(input int d, input int t, input int s);
        if (s == 0) return t;
        if (d < t) return (d + s < t) ? d + s : t;
        if (d > t) return (d - s > t) ? d - s : t;
        return d;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0: return 32'(m_tgt);
            2'd1: return 32'(m_psh);
            2'd2: return 32'(m_step);
            default: return {28'd0, m_done, m_duty != m_tgt, m_ien, m_en};
        endcase
    endfunction

    function automatic void model_reset();
        m_tgt = 0; m_psh = 0; m_pact = 0; m_step = 0; m_cnt = 0; m_duty = 0;
        m_en = 0; m_ien = 0; m_done = 0; m_pwm = 0; m_ramp = 0;
    endfunction

    function automatic void model_update(input bit wr, input logic [1:0] a, input logic [31:0] d);
        int  v, t_eff, s_eff, p_eff, nd;
        bit  tick, en_n, clr;
        v     = int'(d[15:0]);
        t_eff = (wr && a == 2'd0) ? v : m_tgt;
        s_eff = (wr && a == 2'd2) ? v : m_step;
        p_eff = (wr && a == 2'd1) ? v : m_psh;
        tick  = m_en && (m_cnt == m_pact);
        nd    = tick ? ramp(m_duty, t_eff, s_eff) : m_duty;
        en_n  = (wr && a == 2'd3) ? d[0] : m_en;
        clr   = wr && a == 2'd3 && d[3];
        m_pwm = en_n && m_en && (m_cnt < m_duty);
        if (!m_en || tick) begin
            m_pact = p_eff;
            m_cnt  = 0;
        end else m_cnt++;
        m_done = (m_ramp && en_n && nd == t_eff) || (m_done && !clr);
        m_ramp = en_n && nd != t_eff;
        if (wr && a == 2'd3) m_ien = d[1];
        m_tgt = t_eff; m_step = s_eff; m_psh = p_eff; m_duty = nd; m_en = en_n;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input bit cs, input bit w, input logic [1:0] a, input logic [31:0] d);
        chipselect = cs; write_n = !w; address = a; writedata = d;
        q.push_back('{m_pwm, 16'(m_duty), m_done && m_ien, model_rd(a)});
        @(posedge clk);
        model_update(cs && w, a, d);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'd3, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1 v = readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        #2;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_duty", 32'(duty_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_duty(input string n, input int max);
        logic [15:0] p;
        bit ok;
        p = duty_out;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            idle();
            ok = duty_out != p;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout waiting for duty change, duty=%h", n, duty_out);
        end
    endtask

    task automatic count_pwm(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            idle();
            hi += int'(pwm_out);
        end
    endtask

    task automatic wait_model(input int target_cnt, input bool_tick, input int max);
        for (int i = 0; i < max; i++) begin
            if (bool_tick ? (m_en && m_cnt == m_pact) : (m_cnt == target_cnt)) return;
            idle();
        end
        n_tests++; n_fail++;
        $display("FAIL wait_model: timeout, cnt=%0d", m_cnt);
    endtask

    initial begin
        logic [31:0] v;
        int hi;
        model_reset();
        do_reset();
        peek(2'd3, v);
        chk("rst_ctrl", v, 32'd0);

        // constant-step period test
        wr(2'd1, 32'd9); wr(2'd0, 32'd5); wr(2'd2, 32'd0); wr(2'd3, 32'd1);
        wait_duty("period_wait", 30);
        chk("period_duty", 32'(duty_out), 32'd5);
        peek(2'd3, v);
        chk("period_done", 32'(v[3]), 32'd1);
        repeat (2) idle();
        count_pwm(10, hi);
        chk("period_high", 32'(hi), 32'd5);

        // ramp up with interrupt
        do_reset();
        wr(2'd1, 32'd99); wr(2'd2, 32'd20); wr(2'd0, 32'd50); wr(2'd3, 32'd3);
        wait_duty("up1_wait", 150);
        chk("up_duty20", 32'(duty_out), 32'd20);
        chk("up_irq20", 32'(irq), 32'd0);
        wait_duty("up2_wait", 150);
        chk("up_duty40", 32'(duty_out), 32'd40);
        wait_duty("up3_wait", 150);
        chk("up_duty50", 32'(duty_out), 32'd50);
        chk("up_irq50", 32'(irq), 32'd1);

        // saturation both directions, one tick per cycle
        do_reset();
        wr(2'd2, 32'd0); wr(2'd0, 32'hFFF0); wr(2'd1, 32'd0); wr(2'd3, 32'd1);
        idle();
        chk("sat_start", 32'(duty_out), 32'hFFF0);
        wr(2'd2, 32'h8000);
        wr(2'd0, 32'd0);
        chk("sat_down1", 32'(duty_out), 32'h7FF0);
        idle();
        chk("sat_down2", 32'(duty_out), 32'd0);
        wr(2'd2, 32'hFFFF);
        wr(2'd0, 32'hFFFF);
        chk("sat_up1", 32'(duty_out), 32'hFFFF);
        idle();
        chk("sat_up2", 32'(duty_out), 32'hFFFF);

        // boundary duty values and deferred period change
        do_reset();
        wr(2'd1, 32'd3); wr(2'd0, 32'd0); wr(2'd2, 32'd0); wr(2'd3, 32'd1);
        count_pwm(8, hi);
        chk("bnd_zero", 32'(hi), 32'd0);
        wr(2'd0, 32'd4);
        wait_duty("bnd_wait", 10);
        repeat (4) idle();
        count_pwm(8, hi);
        chk("bnd_full", 32'(hi), 32'd8);
        wait_model(1, 1'b0, 10);
        wr(2'd1, 32'd7);
        peek(2'd1, v);
        chk("bnd_shadow", v, 32'd7);
        repeat (8) idle();
        count_pwm(16, hi);
        chk("bnd_newper", 32'(hi), 32'd8);

        // disable mid-ramp, resume, then reset mid-ramp
        do_reset();
        wr(2'd1, 32'd9); wr(2'd2, 32'd50); wr(2'd0, 32'd200); wr(2'd3, 32'd1);
        wait_duty("dis_wait", 30);
        repeat (2) idle();
        chk("dis_pre_pwm", 32'(pwm_out), 32'd1);
        wr(2'd3, 32'd0);
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        chk("dis_duty", 32'(duty_out), 32'd50);
        repeat (15) idle();
        chk("dis_frozen", 32'(duty_out), 32'd50);
        wr(2'd3, 32'd1);
        wait_duty("resume_wait", 30);
        chk("resume_duty", 32'(duty_out), 32'd100);
        do_reset();
        peek(2'd0, v);
        chk("rst_tgt", v, 32'd0);

        // done clear coinciding with completion
        wr(2'd1, 32'd4); wr(2'd0, 32'd3); wr(2'd2, 32'd0); wr(2'd3, 32'd3);
        wait_model(0, 1'b1, 20);
        wr(2'd3, 32'hB);
        peek(2'd3, v);
        chk("coinc_done", 32'(v[3]), 32'd1);
        chk("coinc_irq", 32'(irq), 32'd1);
        wr(2'd3, 32'hB);
        peek(2'd3, v);
        chk("clr_done", 32'(v[3]), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = $urandom & 32'hFFFF_0000;
            case (a)
                2'd0: d = d | 32'($urandom_range(0, 20));
                2'd1: d = d | 32'($urandom_range(0, 6));
                2'd2: d = d | 32'($urandom_range(0, 6));
                default: begin
                    d = $urandom;
                    d[0] = $urandom_range(0, 4) != 0;
                end
            endcase
            step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, a, d);
        end
        idle();
        #10;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nios_system_pwm_ramp_ctrl.md
NIOS_SYSTEM_PWM_RAMP_CTRL -- requirements
Module: nios_system_pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 16, width of the duty, target, period and step fields.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  2  register select: 0 TARGET, 1 PERIOD, 2 STEP, 3 CTRL/STATUS.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  write data; only bits [DUTY_W-1:0] are used, except in CTRL.
REQ-009 readdata  output  32  combinational, zero-wait read of the addressed register, zero-extended.
REQ-010 pwm_out  output  1  PWM waveform.
REQ-011 duty_out  output  DUTY_W  currently applied duty, for mirroring into the PWM PIO.
REQ-012 irq  output  1  level interrupt, equal to done AND irq_en.

Function
REQ-013 CTRL write bits: bit0 enable, bit1 irq_en, bit3 write-1-to-clear done.
- CTRL read bits: bit0 enable, bit1 irq_en, bit2 busy (duty != target), bit3 done.
REQ-014 Period counter cnt SHALL behave as follows.
- When enable=1: counts 0..period_act, wraps to 0.
- The cycle with cnt==period_act is the boundary tick.
- When enable=0: cnt is held at 0.
REQ-015 pwm_out SHALL be registered, equal to enable AND (cnt < duty).
- duty=0 gives constant 0.
- duty > period_act gives constant 1.
REQ-016 PERIOD writes SHALL go to a shadow register, copied to period_act on the next boundary tick.
- While enable=0, the copy is immediate.
REQ-017 duty SHALL change only on a boundary tick.
- step=0: duty := target.
- duty<target: duty := min(duty+step, target).
- duty>target: duty := max(duty-step, target).
- All arithmetic at DUTY_W+1 bits; no wrap-around.
REQ-018 The state machine SHALL have states IDLE, RAMP and HOLD.
- IDLE: entered while enable=0; duty retained.
- RAMP: entered while enable=1 and duty!=target.
- HOLD: entered while enable=1 and duty==target.
REQ-019 On the RAMP->HOLD transition, done SHALL be set; it clears only via a CTRL bit3 write.
- If set and clear coincide, set wins.
REQ-020 A TARGET write mid-ramp SHALL retarget from the current duty at the next boundary, with no restart of cnt.
REQ-021 Clearing enable mid-ramp SHALL force pwm_out=0 on the next cycle and freeze duty.
- Re-enable resumes ramping from the frozen duty.
REQ-022 Writes to TARGET or STEP SHALL take effect at the boundary tick following the write cycle.
- A write in the same cycle as a boundary tick is used at that boundary.

Reset
REQ-023 Reset SHALL clear target, period shadow, period_act, step, enable, irq_en, done, cnt and duty to 0.
- Outputs pwm_out=0, duty_out=0, irq=0, state IDLE.
REQ-024 Reset asserted mid-ramp SHALL abort immediately; there is no resume after release.

Structure
REQ-025 Package nios_pwm_pkg SHALL hold the following.
- DUTY_W default.
- Register address constants.
- CTRL bit positions.
- State enumeration.
REQ-026 Sub-module pwm_ramp_step SHALL implement the combinational saturating next-duty computation of REQ-017.

Verification
REQ-027 Period test: PERIOD=9, TARGET=5, STEP=0, enable -> pwm_out high 5 of every 10 cycles; done set after first boundary.
REQ-028 Ramp-up test: PERIOD=99, STEP=20, TARGET=50 from duty 0 -> duty 20,40,50 at successive boundaries; irq asserts with irq_en=1 at duty=50.
REQ-029 Ramp-down/saturation test: duty=0xFFF0, TARGET=0, STEP=0x8000 -> duty 0x7FF0 then 0, no underflow.
- TARGET=0xFFFF, STEP=0xFFFF -> 0xFFFF, no overflow.
REQ-030 Boundary test: PERIOD=3 with duty=0 -> pwm_out constant 0; duty=4 -> constant 1; PERIOD write mid-period applies only after wrap.
REQ-031 Disruption test: disable mid-ramp -> pwm_out 0 next cycle, duty frozen.
- Reset mid-ramp -> all outputs 0.
- done write-1-clear coinciding with completion -> done stays 1.
